// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 console transmitter on the data-memory bus.
// Software writes bytes into a TX FIFO; a bit-timed FSM shifts them out LSB-first on tx_o.
module dmem_uart_tx #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h000F_FFF0,
   parameter int                    WORD_WIDTH  = 32,
   parameter int                    FIFO_DEPTH  = 8,
   parameter int                    DEFAULT_DIV = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WORD_WIDTH-1:0] wdata_i,
   input  logic [3:0]            we_i,
   output logic [WORD_WIDTH-1:0] rdata_o,
   output logic                  tx_o,
   output logic                  irq_o
);

   localparam int PW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [1:0] R_TXDATA = 2'd0;
   localparam logic [1:0] R_STATUS = 2'd1;
   localparam logic [1:0] R_DIV    = 2'd2;
   localparam logic [1:0] R_CTRL   = 2'd3;

   logic                  sel;
   logic                  is_write;
   logic                  push_req;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic [1:0]            offset;

   logic                  ready_q;
   logic [WORD_WIDTH-1:0] rdata_q;
   logic [WORD_WIDTH-1:0] rd_val;

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr_nx;
   logic [PW-1:0]         rd_ptr_nx;
   logic [PW-1:0]         level;
   logic                  full_q;
   logic                  empty_q;
   logic [7:0]            mem [FIFO_DEPTH];
   logic [7:0]            head;

   logic [15:0]           div_q;
   logic [15:0]           div_raw;
   logic [15:0]           div_wr;
   logic                  irq_en;
   logic                  irq_q;

   // state is the observable FSM encoding (S_IDLE..S_STOP)
   logic [1:0]            state;
   logic [15:0]           timer;
   logic [15:0]           reload;
   logic [2:0]            bit_cnt;
   logic [7:0]            shreg;
   logic                  tx_q;
   logic                  busy;

   logic                  unused_bits;
   assign unused_bits = ^{addr_i[1:0], wdata_i[WORD_WIDTH-1:16]};

   assign offset   = addr_i[3:2];
   assign sel      = valid_i && (addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
   assign is_write = (we_i != 4'b0000);
   assign push_req = (offset == R_TXDATA) && we_i[0];

   // A request is taken only when no response is outstanding; a TXDATA push stalls on full.
   assign accept   = sel && !ready_q && !(push_req && full_q);
   assign push     = accept && push_req;
   assign busy     = (state != S_IDLE);
   assign pop      = !empty_q && ((state == S_IDLE) ||
                                  ((state == S_STOP) && (timer == 16'd0)));

   assign wr_ptr_nx = wr_ptr + {{(PW-1){1'b0}}, push};
   assign rd_ptr_nx = rd_ptr + {{(PW-1){1'b0}}, pop};
   assign level     = wr_ptr - rd_ptr;
   assign head      = mem[rd_ptr[PW-2:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wr_ptr  <= wr_ptr_nx;
         rd_ptr  <= rd_ptr_nx;
         full_q  <= (wr_ptr_nx[PW-1] != rd_ptr_nx[PW-1]) &&
                    (wr_ptr_nx[PW-2:0] == rd_ptr_nx[PW-2:0]);
         empty_q <= (wr_ptr_nx == rd_ptr_nx);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[PW-2:0]] <= wdata_i[7:0];
      end
   end

   // Byte lanes 0/1 update the divisor; anything below 2 cannot time a bit and is clamped.
   always_comb begin
      div_raw = div_q;
      if (we_i[0]) div_raw[7:0]  = wdata_i[7:0];
      if (we_i[1]) div_raw[15:8] = wdata_i[15:8];
   end

   assign div_wr = (div_raw < 16'd2) ? 16'd2 : div_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= 16'(DEFAULT_DIV);
         irq_en <= 1'b0;
      end else if (accept && is_write) begin
         case (offset)
            R_DIV:   div_q <= div_wr;
            R_CTRL:  if (we_i[0]) irq_en <= wdata_i[0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      case (offset)
         R_STATUS: begin
            rd_val[0]      = full_q;
            rd_val[1]      = empty_q;
            rd_val[2]      = busy;
            rd_val[8 +: PW] = level;
         end
         R_DIV:   rd_val[15:0] = div_q;
         R_CTRL:  rd_val[0]    = irq_en;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= accept;
         rdata_q <= (accept && !is_write) ? rd_val : '0;
      end
   end

   // Each state holds for reload cycles; timer counts reload-1 down to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         tx_q    <= 1'b1;
         timer   <= '0;
         reload  <= 16'(DEFAULT_DIV);
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (!empty_q) begin
                  shreg  <= head;
                  reload <= div_q;
                  timer  <= div_q - 16'd1;
                  tx_q   <= 1'b0;
                  state  <= S_START;
               end
            end
            S_START: begin
               if (timer == 16'd0) begin
                  state   <= S_DATA;
                  tx_q    <= shreg[0];
                  timer   <= reload - 16'd1;
                  bit_cnt <= 3'd0;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            S_DATA: begin
               if (timer == 16'd0) begin
                  timer   <= reload - 16'd1;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= S_STOP;
                     tx_q  <= 1'b1;
                  end else begin
                     shreg <= {1'b0, shreg[7:1]};
                     tx_q  <= shreg[1];
                  end
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            S_STOP: begin
               if (timer == 16'd0) begin
                  // Chain straight into the next start bit when more data is queued.
                  if (!empty_q) begin
                     shreg  <= head;
                     reload <= div_q;
                     timer  <= div_q - 16'd1;
                     tx_q   <= 1'b0;
                     state  <= S_START;
                  end else begin
                     tx_q  <= 1'b1;
                     state <= S_IDLE;
                  end
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               tx_q  <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= irq_en && empty_q && (state == S_IDLE);
   end

   assign ready_o = ready_q;
   assign rdata_o = rdata_q;
   assign tx_o    = tx_q;
   assign irq_o   = irq_q;

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Bench for dmem_uart_tx: bus driver tasks, a per-cycle log of tx_o, and
// scenario tasks comparing the line against frames built from byte/divisor rules.
module tb_dmem_uart_tx;

   localparam logic [31:0] BASE  = 32'h000F_FFF0;
   localparam int          LOG_N = 32768;
   localparam logic [1:0]  R_TX  = 2'd0;
   localparam logic [1:0]  R_ST  = 2'd1;
   localparam logic [1:0]  R_DIV = 2'd2;
   localparam logic [1:0]  R_CTL = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic        ready;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  we;
   logic [31:0] rdata;
   logic        tx;
   logic        irq;

   int          n_pass = 0;
   int          n_chk = 0;
   int          drv_timeouts = 0;
   int          cyc = 0;
   int          last_acc;
   logic [31:0] last_rd;
   bit          last_ok;
   bit          tx_log [LOG_N];
   logic [7:0]  exp_q [$];

   dmem_uart_tx dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid),
      .ready_o (ready),
      .addr_i  (addr),
      .wdata_i (wdata),
      .we_i    (we),
      .rdata_o (rdata),
      .tx_o    (tx),
      .irq_o   (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < LOG_N) tx_log[cyc] = tx;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                       input int budget, input bit expect_ack);
      valid   = 1'b1;
      addr    = a;
      wdata   = d;
      we      = w;
      last_ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (ready) begin
            last_ok  = 1'b1;
            last_rd  = rdata;
            last_acc = cyc - 1;
            break;
         end
      end
      valid = 1'b0;
      we    = 4'h0;
      if (!last_ok && expect_ack) drv_timeouts++;
   endtask

   task automatic wr(input logic [1:0] off, input logic [31:0] d);
      xfer(BASE + {28'd0, off, 2'b00}, d, 4'hF, 200, 1'b1);
   endtask

   task automatic rd(input logic [1:0] off);
      xfer(BASE + {28'd0, off, 2'b00}, 32'h0, 4'h0, 200, 1'b1);
   endtask

   // Mismatching cycles between the log and an ideal 8N1 frame of byte b starting at 'start'.
   function automatic int frame_errs(input int start, input int div, input logic [7:0] b);
      logic [9:0] fr;
      int e;
      fr = {1'b1, b, 1'b0};
      e  = 0;
      for (int k = 0; k < 10 * div; k++) begin
         if (start + k >= LOG_N) e++;
         else if (tx_log[start + k] != fr[k / div]) e++;
      end
      return e;
   endfunction

   task automatic test_reset();
      rst   = 1'b1;
      valid = 1'b0;
      addr  = '0;
      wdata = '0;
      we    = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", ready); else n_pass++;
      n_chk++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h expected 0", rdata); else n_pass++;
      n_chk++; if (tx !== 1'b1) $display("FAIL rst_tx: got %b expected 1", tx); else n_pass++;
      n_chk++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b expected 0", irq); else n_pass++;
      rst = 1'b0;
      step();
      wr(R_DIV, 32'd4);
      wr(R_TX, 32'h00);
      repeat (10) step();
      n_chk++; if (tx !== 1'b0) $display("FAIL midframe_low: got %b expected 0", tx); else n_pass++;
      rst = 1'b1;
      step();
      n_chk++; if (tx !== 1'b1) $display("FAIL midrst_tx: got %b expected 1", tx); else n_pass++;
      n_chk++; if (ready !== 1'b0) $display("FAIL midrst_ready: got %b expected 0", ready); else n_pass++;
      n_chk++; if (irq !== 1'b0) $display("FAIL midrst_irq: got %b expected 0", irq); else n_pass++;
      rst = 1'b0;
      step();
      rd(R_ST);
      n_chk++; if (last_rd !== 32'h2) $display("FAIL rst_status: got %h expected 00000002", last_rd); else n_pass++;
      rd(R_DIV);
      n_chk++; if (last_rd !== 32'd16) $display("FAIL rst_div: got %0d expected 16", last_rd); else n_pass++;
   endtask

   task automatic test_single();
      int s;
      int errs;
      wr(R_DIV, 32'd4);
      wr(R_TX, 32'h55);
      s = last_acc + 2;
      rd(R_ST);
      n_chk++; if (last_rd !== 32'h6) $display("FAIL single_status: got %h expected 00000006", last_rd); else n_pass++;
      wait_until(s + 44);
      errs = frame_errs(s, 4, 8'h55);
      n_chk++; if (errs !== 0) $display("FAIL single_frame: got %0d bad cycles expected 0", errs); else n_pass++;
      n_chk++; if (tx_log[s-1] !== 1'b1) $display("FAIL single_pre_idle: got %b expected 1", tx_log[s-1]); else n_pass++;
      n_chk++; if (tx_log[s+40] !== 1'b1) $display("FAIL single_post_idle: got %b expected 1", tx_log[s+40]); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int s;
      int errs;
      int div;
      int n;
      logic [7:0] b;
      wr(R_TX, 32'hA5);
      s = last_acc + 2;
      wr(R_TX, 32'h3C);
      wait_until(s + 84);
      errs = frame_errs(s, 4, 8'hA5);
      n_chk++; if (errs !== 0) $display("FAIL b2b_first: got %0d bad cycles expected 0", errs); else n_pass++;
      errs = frame_errs(s + 40, 4, 8'h3C);
      n_chk++; if (errs !== 0) $display("FAIL b2b_second: got %0d bad cycles expected 0", errs); else n_pass++;
      for (int r = 0; r < 4; r++) begin
         div = $urandom_range(2, 6);
         n   = $urandom_range(1, 3);
         wr(R_DIV, div);
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            wr(R_TX, {24'h0, b});
            if (k == 0) s = last_acc + 2;
         end
         wait_until(s + n * 10 * div + 2);
         for (int k = 0; k < n; k++) begin
            b    = exp_q.pop_front();
            errs = frame_errs(s + k * 10 * div, div, b);
            n_chk++;
            if (errs !== 0) $display("FAIL rand_frame r%0d k%0d byte %h: got %0d bad cycles expected 0", r, k, b, errs);
            else n_pass++;
         end
      end
   endtask

   task automatic test_overflow();
      int s;
      int errs;
      logic [7:0] b;
      exp_q.delete();
      wr(R_DIV, 32'd100);
      for (int k = 0; k < 9; k++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         wr(R_TX, {24'h0, b});
         if (k == 0) s = last_acc + 2;
      end
      // One byte is already in the shifter, so the next eight fill the FIFO.
      rd(R_ST);
      n_chk++; if (last_rd !== 32'h805) $display("FAIL ovf_status: got %h expected 00000805", last_rd); else n_pass++;
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      xfer(BASE, {24'h0, b}, 4'hF, 3000, 1'b1);
      n_chk++; if (last_acc !== s + 1000) $display("FAIL ovf_stall_accept: got %0d expected %0d", last_acc, s + 1000); else n_pass++;
      wait_until(s + 10 * 1000 + 2);
      for (int k = 0; k < 10; k++) begin
         b    = exp_q.pop_front();
         errs = frame_errs(s + k * 1000, 100, b);
         n_chk++;
         if (errs !== 0) $display("FAIL ovf_frame k%0d byte %h: got %0d bad cycles expected 0", k, b, errs);
         else n_pass++;
      end
   endtask

   task automatic test_div();
      int s;
      int errs;
      int hi;
      logic [7:0] b0;
      logic [7:0] b1;
      wr(R_DIV, 32'd0);
      rd(R_DIV);
      n_chk++; if (last_rd !== 32'd2) $display("FAIL div_clamp0: got %0d expected 2", last_rd); else n_pass++;
      wr(R_DIV, 32'd1);
      rd(R_DIV);
      n_chk++; if (last_rd !== 32'd2) $display("FAIL div_clamp1: got %0d expected 2", last_rd); else n_pass++;
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      wr(R_TX, {24'h0, b0});
      s = last_acc + 2;
      wr(R_TX, {24'h0, b1});
      wr(R_DIV, 32'd8);
      rd(R_DIV);
      n_chk++; if (last_rd !== 32'd8) $display("FAIL div_readback: got %0d expected 8", last_rd); else n_pass++;
      wait_until(s + 20 + 80 + 6);
      errs = frame_errs(s, 2, b0);
      n_chk++; if (errs !== 0) $display("FAIL div_old_frame: got %0d bad cycles expected 0", errs); else n_pass++;
      errs = frame_errs(s + 20, 8, b1);
      n_chk++; if (errs !== 0) $display("FAIL div_new_frame: got %0d bad cycles expected 0", errs); else n_pass++;
      hi = 0;
      for (int c = s + 100; c < s + 105; c++) hi += tx_log[c];
      n_chk++; if (hi !== 5) $display("FAIL div_idle_after: got %0d high cycles expected 5", hi); else n_pass++;
   endtask

   task automatic test_irq();
      int s;
      wr(R_CTL, 32'h1);
      n_chk++; if (irq !== 1'b0) $display("FAIL irq_before: got %b expected 0", irq); else n_pass++;
      step();
      n_chk++; if (irq !== 1'b1) $display("FAIL irq_rise: got %b expected 1", irq); else n_pass++;
      wr(R_TX, {24'h0, 8'($urandom_range(0, 255))});
      s = last_acc + 2;
      step();
      n_chk++; if (irq !== 1'b0) $display("FAIL irq_drop: got %b expected 0", irq); else n_pass++;
      wait_until(s + 80);
      n_chk++; if (irq !== 1'b0) $display("FAIL irq_frame_end: got %b expected 0", irq); else n_pass++;
      step();
      n_chk++; if (irq !== 1'b1) $display("FAIL irq_after_frame: got %b expected 1", irq); else n_pass++;
      wr(R_CTL, 32'h0);
      step();
      n_chk++; if (irq !== 1'b0) $display("FAIL irq_disable: got %b expected 0", irq); else n_pass++;
   endtask

   task automatic test_decode();
      xfer(BASE + 32'h10, 32'h0, 4'h0, 20, 1'b0);
      n_chk++; if (last_ok !== 1'b0) $display("FAIL decode_above: got ready %b expected 0", last_ok); else n_pass++;
      xfer(BASE - 32'h10, 32'h41, 4'hF, 20, 1'b0);
      n_chk++; if (last_ok !== 1'b0) $display("FAIL decode_below: got ready %b expected 0", last_ok); else n_pass++;
      xfer(BASE, 32'h42, 4'b0010, 200, 1'b1);
      wr(R_ST, 32'hFFFF_FFFF);
      rd(R_ST);
      n_chk++; if (last_rd !== 32'h2) $display("FAIL decode_no_push: got %h expected 00000002", last_rd); else n_pass++;
      rd(R_TX);
      n_chk++; if (last_rd !== 32'h0) $display("FAIL txdata_read: got %h expected 00000000", last_rd); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_div();
      test_irq();
      test_decode();
      n_chk++;
      if (drv_timeouts !== 0) $display("FAIL bus_timeouts: got %0d expected 0", drv_timeouts);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
